// File: rtl/conv_ctrl_strided.sv
// Sequencer for the strided 1D convolution datapath: per-job config, x/f memory loads,
// windowed reads driving the accumulator, and a valid/ready result stream.
module conv_ctrl_strided #(
  parameter int MAX_DATA_N      = 16,
  parameter int LG_MAX_DATA_N   = 4,
  parameter int MAX_FILTER_N    = 8,
  parameter int LG_MAX_FILTER_N = 3,
  parameter int LG_STRIDE       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [LG_MAX_DATA_N:0]     cfg_data_len,
  input  logic [LG_MAX_FILTER_N:0]   cfg_filter_len,
  input  logic [LG_STRIDE-1:0]       cfg_stride,
  output logic                       cfg_err,
  input  logic                       s_valid_x,
  output logic                       s_ready_x,
  output logic [LG_MAX_DATA_N-1:0]   addr_x,
  output logic                       wr_en_x,
  input  logic                       s_valid_f,
  output logic                       s_ready_f,
  output logic [LG_MAX_FILTER_N-1:0] addr_f,
  output logic                       wr_en_f,
  output logic                       m_valid_y,
  input  logic                       m_ready_y,
  output logic                       m_last_y,
  output logic                       clear_acc,
  output logic                       en_acc,
  output logic                       busy
);

  // state   | meaning
  // IDLE    | waiting for a config, cfg_ready high
  // LOAD    | writing x and f memories from the load streams
  // COMPUTE | issuing one read per tap of the current window
  // DRAIN   | final accumulate of the last tap's read data
  // OUT     | result presented until accepted
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, OUT} state_t;

  localparam int DW = LG_MAX_DATA_N + 1;
  localparam int FW = LG_MAX_FILTER_N + 1;
  localparam int EW = LG_MAX_DATA_N + 2;

  state_t state, state_nxt;
  logic [DW-1:0] len_l, x_cnt, base;
  logic [FW-1:0] len_k, f_cnt, k_cnt;
  logic [LG_STRIDE-1:0] stride;
  logic en_acc_q;

  logic cfg_ok, hs_x, hs_f, x_done_nxt, f_done_nxt, last_tap, win_last;
  logic [EW-1:0] win_end;

  assign cfg_ok = (cfg_filter_len != '0) && (cfg_filter_len <= FW'(MAX_FILTER_N)) &&
                  (DW'(cfg_filter_len) <= cfg_data_len) &&
                  (cfg_data_len <= DW'(MAX_DATA_N)) && (cfg_stride != '0);

  assign hs_x = (state == LOAD) && s_valid_x && (x_cnt < len_l);
  assign hs_f = (state == LOAD) && s_valid_f && (f_cnt < len_k);
  // Look ahead so COMPUTE starts the cycle right after the last load beat.
  assign x_done_nxt = (x_cnt + DW'(hs_x)) == len_l;
  assign f_done_nxt = (f_cnt + FW'(hs_f)) == len_k;
  assign last_tap = (k_cnt == len_k - FW'(1));
  // Wide enough that base+S+K cannot wrap.
  assign win_end = EW'(base) + EW'(stride) + EW'(len_k);
  assign win_last = win_end > EW'(len_l);

  assign en_acc = en_acc_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len_l    <= '0;
      len_k    <= '0;
      stride   <= '0;
      x_cnt    <= '0;
      f_cnt    <= '0;
      k_cnt    <= '0;
      base     <= '0;
      en_acc_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      en_acc_q <= (state == COMPUTE);
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ok) begin
            len_l  <= cfg_data_len;
            len_k  <= cfg_filter_len;
            stride <= cfg_stride;
            x_cnt  <= '0;
            f_cnt  <= '0;
            k_cnt  <= '0;
            base   <= '0;
          end
        end
        LOAD: begin
          if (hs_x) x_cnt <= x_cnt + DW'(1);
          if (hs_f) f_cnt <= f_cnt + FW'(1);
        end
        COMPUTE: k_cnt <= last_tap ? '0 : k_cnt + FW'(1);
        OUT: begin
          if (m_ready_y && !win_last) base <= base + DW'(stride);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    s_ready_x = 1'b0;
    s_ready_f = 1'b0;
    addr_x    = '0;
    addr_f    = '0;
    wr_en_x   = 1'b0;
    wr_en_f   = 1'b0;
    m_valid_y = 1'b0;
    m_last_y  = 1'b0;
    clear_acc = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_ok) state_nxt = LOAD;
          else        cfg_err   = 1'b1;
        end
      end
      LOAD: begin
        s_ready_x = (x_cnt < len_l);
        s_ready_f = (f_cnt < len_k);
        addr_x    = x_cnt[LG_MAX_DATA_N-1:0];
        addr_f    = f_cnt[LG_MAX_FILTER_N-1:0];
        wr_en_x   = hs_x;
        wr_en_f   = hs_f;
        if (x_done_nxt && f_done_nxt) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        addr_x    = base[LG_MAX_DATA_N-1:0] + LG_MAX_DATA_N'(k_cnt);
        addr_f    = k_cnt[LG_MAX_FILTER_N-1:0];
        clear_acc = (k_cnt == '0);
        if (last_tap) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        m_valid_y = 1'b1;
        m_last_y  = win_last;
        if (m_ready_y) state_nxt = win_last ? IDLE : COMPUTE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_ctrl_strided.sv
// Bench for conv_ctrl_strided: drives config/load/result streams and checks against a
// window-list model plus a behavioural memory/accumulator datapath.
module tb_conv_ctrl_strided;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_valid = 1'b0, cfg_ready, cfg_err;
  logic [4:0] cfg_data_len = '0;
  logic [3:0] cfg_filter_len = '0;
  logic [1:0] cfg_stride = '0;
  logic s_valid_x = 1'b0, s_ready_x, wr_en_x;
  logic s_valid_f = 1'b0, s_ready_f, wr_en_f;
  logic [3:0] addr_x;
  logic [2:0] addr_f;
  logic m_valid_y, m_ready_y = 1'b0, m_last_y;
  logic clear_acc, en_acc, busy;

  int n_checks = 0;
  int n_errors = 0;

  int x_data = 0, f_data = 0;
  int xmem [16];
  int fmem [8];
  int rdx = 0, rdf = 0, acc = 0;

  conv_ctrl_strided dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data_len(cfg_data_len), .cfg_filter_len(cfg_filter_len), .cfg_stride(cfg_stride),
    .cfg_err(cfg_err),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .addr_f(addr_f), .wr_en_f(wr_en_f),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .m_last_y(m_last_y),
    .clear_acc(clear_acc), .en_acc(en_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath model: synchronous memories with 1-cycle read, accumulator.
  always @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= x_data;
    if (wr_en_f) fmem[addr_f] <= f_data;
    rdx <= xmem[addr_x];
    rdf <= fmem[addr_f];
    if (clear_acc) acc <= 0;
    else if (en_acc) acc <= acc + rdx * rdf;
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0 || s_ready_x !== 1'b0 ||
        s_ready_f !== 1'b0 || wr_en_x !== 1'b0 || wr_en_f !== 1'b0 || addr_x !== 4'd0 ||
        addr_f !== 3'd0 || m_valid_y !== 1'b0 || m_last_y !== 1'b0 || clear_acc !== 1'b0 ||
        en_acc !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: cfg_ready=%b busy=%b err=%b rx=%b rf=%b wx=%b wf=%b ax=%0d af=%0d mv=%b ml=%b clr=%b en=%b (want cfg_ready=1, rest 0)",
               cfg_ready, busy, cfg_err, s_ready_x, s_ready_f, wr_en_x, wr_en_f, addr_x, addr_f,
               m_valid_y, m_last_y, clear_acc, en_acc);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one job end to end. abort_win >= 0 asserts reset during tap 2 of that window.
  task automatic run_job(input int L, input int K, input int S, input bit f_gap,
                         input int stall, input bit stall_rand, input bit fixed,
                         input int abort_win);
    int xd [16];
    int fd [8];
    int wins[$];
    int xi, fi, cyc, b, n, exp_acc;
    bit vx, vf, ex, ef;
    for (int i = 0; i < 16; i++) xd[i] = fixed ? i + 1 : int'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++)  fd[i] = fixed ? 1 : int'($urandom_range(0, 255));
    b = 0;
    while (b + K <= L) begin
      wins.push_back(b);
      b += S;
    end

    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data_len = 5'(L);
    cfg_filter_len = 4'(K);
    cfg_stride = 2'(S);
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_accept L=%0d K=%0d S=%0d: cfg_ready=%b cfg_err=%b (want 1,0)", L, K, S, cfg_ready, cfg_err);
    end
    @(negedge clk);
    cfg_valid = 1'b0;

    xi = 0; fi = 0; cyc = 0;
    while (!(xi == L && fi == K) && cyc < 300) begin
      vx = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
      vf = f_gap ? (cyc % 2 == 0) : (fixed ? 1'b1 : ($urandom_range(0, 3) != 0));
      s_valid_x = vx;
      s_valid_f = vf;
      x_data = xd[(xi < L) ? xi : 0];
      f_data = fd[(fi < K) ? fi : 0];
      ex = vx && (xi < L);
      ef = vf && (fi < K);
      #1;
      n_checks++;
      if (s_ready_x !== (xi < L) || s_ready_f !== (fi < K) || busy !== 1'b1 ||
          m_valid_y !== 1'b0 || clear_acc !== 1'b0 || en_acc !== 1'b0) begin
        n_errors++;
        $display("FAIL load_ready cyc=%0d: rx=%b rf=%b busy=%b mv=%b clr=%b en=%b (want rx=%b rf=%b busy=1 others 0)",
                 cyc, s_ready_x, s_ready_f, busy, m_valid_y, clear_acc, en_acc, xi < L, fi < K);
      end
      n_checks++;
      if (wr_en_x !== ex || (ex && addr_x !== 4'(xi))) begin
        n_errors++;
        $display("FAIL load_x_write cyc=%0d: wr_en_x=%b addr_x=%0d (want %b addr %0d)", cyc, wr_en_x, addr_x, ex, xi);
      end
      n_checks++;
      if (wr_en_f !== ef || (ef && addr_f !== 3'(fi))) begin
        n_errors++;
        $display("FAIL load_f_write cyc=%0d: wr_en_f=%b addr_f=%0d (want %b addr %0d)", cyc, wr_en_f, addr_f, ef, fi);
      end
      if (ex) xi++;
      if (ef) fi++;
      cyc++;
      @(negedge clk);
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    if (cyc >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL load_timeout: xi=%0d fi=%0d (want %0d %0d)", xi, fi, L, K);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end

    for (int w = 0; w < wins.size(); w++) begin
      b = wins[w];
      exp_acc = 0;
      for (int j = 0; j < K; j++) exp_acc += xd[b + j] * fd[j];
      for (int k = 0; k < K; k++) begin
        #1;
        n_checks++;
        if (clear_acc !== (k == 0) || en_acc !== (k != 0) || addr_x !== 4'(b + k) ||
            addr_f !== 3'(k) || wr_en_x !== 1'b0 || wr_en_f !== 1'b0 || m_valid_y !== 1'b0) begin
          n_errors++;
          $display("FAIL compute w=%0d k=%0d: clr=%b en=%b ax=%0d af=%0d wx=%b wf=%b mv=%b (want clr=%b en=%b ax=%0d af=%0d, writes 0, mv 0)",
                   w, k, clear_acc, en_acc, addr_x, addr_f, wr_en_x, wr_en_f, m_valid_y, k == 0, k != 0, b + k, k);
        end
        if (w == abort_win && k == 2) begin
          reset = 1'b0;
          #1;
          n_checks++;
          if (cfg_ready !== 1'b1 || busy !== 1'b0 || en_acc !== 1'b0 || clear_acc !== 1'b0 ||
              addr_x !== 4'd0 || addr_f !== 3'd0 || m_valid_y !== 1'b0 || s_ready_x !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: cfg_ready=%b busy=%b en=%b clr=%b ax=%0d af=%0d mv=%b rx=%b (want cfg_ready=1, rest 0)",
                     cfg_ready, busy, en_acc, clear_acc, addr_x, addr_f, m_valid_y, s_ready_x);
          end
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        @(negedge clk);
      end
      #1;
      n_checks++;
      if (en_acc !== 1'b1 || clear_acc !== 1'b0 || m_valid_y !== 1'b0 || addr_x !== 4'd0) begin
        n_errors++;
        $display("FAIL drain w=%0d: en=%b clr=%b mv=%b ax=%0d (want en=1 clr=0 mv=0 ax=0)", w, en_acc, clear_acc, m_valid_y, addr_x);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (m_valid_y !== 1'b1 || m_last_y !== (w == wins.size() - 1)) begin
        n_errors++;
        $display("FAIL out_valid w=%0d base=%0d: m_valid=%b m_last=%b (want 1,%b)", w, b, m_valid_y, m_last_y, w == wins.size() - 1);
      end
      n_checks++;
      if (acc !== exp_acc) begin
        n_errors++;
        $display("FAIL out_result w=%0d base=%0d: acc=%0d (want %0d)", w, b, acc, exp_acc);
      end
      n = stall_rand ? int'($urandom_range(0, stall)) : stall;
      for (int s = 0; s < n; s++) begin
        @(negedge clk);
        #1;
        n_checks++;
        if (m_valid_y !== 1'b1 || m_last_y !== (w == wins.size() - 1) || en_acc !== 1'b0 ||
            clear_acc !== 1'b0 || addr_x !== 4'd0 || addr_f !== 3'd0 || acc !== exp_acc) begin
          n_errors++;
          $display("FAIL stall w=%0d s=%0d: mv=%b ml=%b en=%b clr=%b ax=%0d af=%0d acc=%0d (want mv=1 ml=%b en=0 clr=0 addr 0 acc=%0d)",
                   w, s, m_valid_y, m_last_y, en_acc, clear_acc, addr_x, addr_f, acc, w == wins.size() - 1, exp_acc);
        end
      end
      m_ready_y = 1'b1;
      #1;
      n_checks++;
      if (m_valid_y !== 1'b1) begin
        n_errors++;
        $display("FAIL handshake w=%0d: m_valid=%b (want 1)", w, m_valid_y);
      end
      @(negedge clk);
      m_ready_y = 1'b0;
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || m_valid_y !== 1'b0) begin
      n_errors++;
      $display("FAIL job_end L=%0d K=%0d S=%0d: busy=%b cfg_ready=%b mv=%b (want 0,1,0)", L, K, S, busy, cfg_ready, m_valid_y);
    end
  endtask

  task automatic test_cfg_errors();
    int cases [5][3] = '{'{8, 0, 1}, '{8, 9, 1}, '{4, 5, 1}, '{8, 4, 0}, '{17, 4, 1}};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data_len = 5'(cases[c][0]);
      cfg_filter_len = 4'(cases[c][1]);
      cfg_stride = 2'(cases[c][2]);
      #1;
      n_checks++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL cfg_err_pulse case=%0d: cfg_err=%b cfg_ready=%b (want 1,1)", c, cfg_err, cfg_ready);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || s_ready_x !== 1'b0 || s_ready_f !== 1'b0) begin
        n_errors++;
        $display("FAIL cfg_err_after case=%0d: cfg_err=%b busy=%b rx=%b rf=%b (want all 0)", c, cfg_err, busy, s_ready_x, s_ready_f);
      end
    end
  endtask

  task automatic test_basic();       run_job(8, 4, 1, 1'b0, 0, 1'b0, 1'b1, -1); endtask
  task automatic test_stride();      run_job(8, 3, 2, 1'b0, 1, 1'b0, 1'b0, -1); endtask
  task automatic test_interleaved(); run_job(8, 4, 1, 1'b1, 0, 1'b0, 1'b1, -1); endtask
  task automatic test_backpressure(); run_job(8, 4, 2, 1'b0, 5, 1'b0, 1'b0, -1); endtask

  task automatic test_reset_mid();
    run_job(8, 4, 1, 1'b0, 0, 1'b0, 1'b1, 1);
    run_job(4, 4, 1, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_boundaries();
    run_job(1, 1, 1, 1'b0, 0, 1'b0, 1'b0, -1);
    run_job(16, 8, 3, 1'b0, 2, 1'b1, 1'b0, -1);
    run_job(16, 1, 1, 1'b0, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_random();
    int k, l, s;
    for (int r = 0; r < 10; r++) begin
      k = int'($urandom_range(1, 8));
      l = int'($urandom_range(k, 16));
      s = int'($urandom_range(1, 3));
      run_job(l, k, s, 1'b0, 3, 1'b1, 1'b0, -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_cfg_errors();
    test_interleaved();
    test_backpressure();
    test_reset_mid();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
